// File: rtl/icmp_echo_payload_buf_if.sv
// Bus bundle between the ICMP core and the echo payload buffer.
// master = ICMP core side, slave = payload buffer.
`timescale 1ns/1ps
interface icmp_echo_payload_buf_if;
    logic        rec_en;
    logic [7:0]  rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;
    logic        tx_req;
    logic        tx_done;
    logic        tx_start_en;
    logic [7:0]  tx_data;
    logic [15:0] tx_byte_num;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        busy;
    logic [15:0] drop_cnt;

    modport master (
        output rec_en, rec_data, rec_pkt_done, rec_byte_num, tx_req, tx_done,
        input  tx_start_en, tx_data, tx_byte_num, des_mac, des_ip, busy, drop_cnt
    );

    modport slave (
        input  rec_en, rec_data, rec_pkt_done, rec_byte_num, tx_req, tx_done,
        output tx_start_en, tx_data, tx_byte_num, des_mac, des_ip, busy, drop_cnt
    );
endinterface

// File: rtl/icmp_echo_payload_buf.sv
// Single-packet echo payload buffer: captures an ICMP echo-request payload,
// kicks the tx path with the stored length, then replays the bytes on tx_req.
// Packets completing while a reply is in flight are dropped and counted.
`timescale 1ns/1ps
module icmp_echo_payload_buf #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned AW      = 10,
    parameter logic [47:0] DES_MAC = 48'h84_A9_38_BF_C9_A0,
    parameter logic [31:0] DES_IP  = {8'd169, 8'd254, 8'd51, 8'd120}
) (
    input logic                    clk,
    input logic                    rst_n,
    icmp_echo_payload_buf_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        START = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam logic [AW:0] PTR_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [15:0] LEN_MAX  = 16'(DEPTH);

    state_t      r_state;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [15:0] r_tx_byte_num;
    logic        r_tx_start_en;
    logic        r_busy;
    logic [15:0] r_drop_cnt;
    logic [7:0]  r_tx_data;

    logic [7:0]  r_mem [DEPTH];
    logic [7:0]  r_ram_q;
    logic        r_rd_req;
    logic        r_rd_hit;

    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [15:0]   w_len_clip;
    logic          w_rd_hit;
    logic          w_rd_req;

    assign w_len_clip = (bus.rec_byte_num > LEN_MAX) ? LEN_MAX : bus.rec_byte_num;
    assign w_rd_hit   = (16'(r_rd_ptr) < r_tx_byte_num);
    assign w_rd_req   = (r_state == SEND) && bus.tx_req;

    // Buffer write port: only IDLE/RECV accept bytes, and never past DEPTH.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        case (r_state)
            IDLE: begin
                if (bus.rec_en) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = '0;
                end
            end
            RECV: begin
                if (bus.rec_en && (r_wr_ptr != PTR_FULL)) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_wr_ptr[AW-1:0];
                end
            end
            default: ;
        endcase
    end

    // Payload RAM: synchronous write, registered read at the current rd_ptr.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= bus.rec_data;
        end
        r_ram_q <= r_mem[r_rd_ptr[AW-1:0]];
    end

    // Control FSM with registered busy/start/length/drop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_tx_byte_num <= '0;
            r_tx_start_en <= 1'b0;
            r_busy        <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_tx_start_en <= 1'b0;

            if (((r_state == START) || (r_state == SEND)) && bus.rec_pkt_done &&
                (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end

            case (r_state)
                IDLE: begin
                    r_wr_ptr <= '0;
                    if (bus.rec_pkt_done) begin
                        // A lone byte arriving with the done pulse is a 1-byte
                        // packet; a bare done pulse is an empty payload.
                        r_tx_byte_num <= bus.rec_en ? w_len_clip : '0;
                        r_rd_ptr      <= '0;
                        r_state       <= START;
                        r_busy        <= 1'b1;
                    end else if (bus.rec_en) begin
                        r_wr_ptr <= PTR_ONE;
                        r_state  <= RECV;
                        r_busy   <= 1'b1;
                    end
                end
                RECV: begin
                    if (bus.rec_en && (r_wr_ptr != PTR_FULL)) begin
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    end
                    if (bus.rec_pkt_done) begin
                        r_tx_byte_num <= w_len_clip;
                        r_rd_ptr      <= '0;
                        r_state       <= START;
                    end
                end
                START: begin
                    r_tx_start_en <= 1'b1;
                    r_state       <= SEND;
                end
                SEND: begin
                    if (bus.tx_req && w_rd_hit) begin
                        r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    end
                    if (bus.tx_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline: request tagged alongside the RAM read, byte (or 0x00
    // beyond the stored length) lands on tx_data the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_req  <= 1'b0;
            r_rd_hit  <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_rd_req <= w_rd_req;
            r_rd_hit <= w_rd_req && w_rd_hit;
            if (r_rd_req) begin
                r_tx_data <= r_rd_hit ? r_ram_q : 8'h00;
            end
        end
    end

    assign bus.tx_start_en = r_tx_start_en;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_byte_num = r_tx_byte_num;
    assign bus.des_mac     = DES_MAC;
    assign bus.des_ip      = DES_IP;
    assign bus.busy        = r_busy;
    assign bus.drop_cnt    = r_drop_cnt;

endmodule
